hdc_job_dispatcher: RTL and testbench
=====================================

Name: hdc_job_dispatcher

Overview:
- Initiator/feeder for the horizontal-distance calculator core (controller plus datapath).
- Accepts (v, x) jobs over a valid/ready stream and buffers them in a small FIFO.
- Drives each job into the core with a one-cycle start pulse and holds the operands stable until the core's level-type done rises.
- Returns the captured Q5.11 result, tagged, over a valid/ready output stream.

Parameters:
- DATA_W, 16, operand/result width (Q5.11 fixed point; 1.0 = 16'h0800).
- DEPTH, 4, job FIFO entries (power of two, >= 2).
- TAG_W, 4, job sequence tag width.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT_HIGH (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  FIFO can accept (= !full).
- job_v  in  DATA_W  velocity operand.
- job_x  in  DATA_W  angle/series operand.
- calc_start  out  1  one-cycle start pulse to the core.
- calc_v  out  DATA_W  operand to the core; held stable for the whole job.
- calc_x  out  DATA_W  operand to the core; held stable for the whole job.
- calc_done  in  1  core done flag (level; stays high until the core's next start clears it).
- calc_result  in  DATA_W  core final_result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DATA_W  captured result.
- res_tag  out  TAG_W  tag of the job that produced the result.
- res_err  out  1  job aborted by timeout (tied 0 when the feature is off).
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (async, active high): FIFO empty, tag counter 0, FSM to IDLE, calc_start=0, calc_v=calc_x=0, res_valid=0, res_data=0, res_tag=0, res_err=0.
- Push: occurs on job_valid & job_ready. The entry stores {v, x, tag}, then the tag counter increments, wrapping 2^TAG_W-1 -> 0. job_ready depends only on full, so a push while full is impossible. Simultaneous push and pop while full: the push is refused, because ready was already low.
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH.
  - IDLE: pop when FIFO is non-empty AND (!res_valid OR res_ready). On pop, load calc_v, calc_x and the current-job tag registers, then go to START.
  - START: calc_start=1 for exactly this cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until calc_done==0. This prevents a stale done from the previous job being accepted. Then go to WAIT_HIGH.
  - WAIT_HIGH: on calc_done==1, register calc_result into res_data and the job tag into res_tag, set res_valid=1 and res_err=0, then return to IDLE.
- Latency:
  - Push-to-calc_start is 2 cycles when idle and empty: FIFO write, then pop, then START.
  - Done-to-res_valid is 1 cycle.
- Output handshake: res_valid drops on res_valid & res_ready unless a new capture happens in the same cycle. New capture has priority, and the new data replaces the old. Capture can only coincide with a drain, because pop required the result slot to be free.
- Outputs res_data, res_tag and res_err stay stable while res_valid & !res_ready.
- Results emerge in strict push order; the tag sequence is gap-free.
- Data is passed through with no arithmetic or rescaling.
- calc_v and calc_x keep their last value after a job completes.

Optional Feature:
- Macro: HDC_DISPATCH_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_LOW and counts every cycle in WAIT_LOW and WAIT_HIGH.
  - At TIMEOUT_CYCLES without done, the job is aborted: res_valid=1, res_data=0, res_err=1, return to IDLE.
  - The next job proceeds normally.
- Undefined: no counter; the FSM waits indefinitely and res_err is constant 0.

Decomposition:
- Package hdc_pkg holds:
  - the state enum (IDLE/START/WAIT_LOW/WAIT_HIGH);
  - FIXED_ONE = 16'h0800;
  - a job struct {v, x, tag}.
- One natural sub-module: hdc_sync_fifo (parameterised depth/width, async active-high reset, push/pop/full/empty).
- FSM and result register stay in the top-level block.

Test Plan:
- Single job, ready output: push v=16'h1000, x=16'h0400; model the core with done after 10 cycles and result=16'h0C00.
  - Expect calc_start at cycle 2.
  - Expect res_valid 1 cycle after done, with res_data=16'h0C00 and res_tag=0.
- Burst of 5 pushes with DEPTH=4 while the core is slow: job_ready drops after the FIFO fills; all 5 results arrive in order with tags 0..4.
- Backpressure: hold res_ready=0 for 20 cycles with 2 jobs queued.
  - The second job must not start.
  - res_data stays stable.
  - Releasing res_ready lets the second job start the next cycle.
- Stale done: calc_done held high through START and dropped 3 cycles later, then raised. Expect the result captured only after the new rise, not earlier.
- Reset mid-WAIT_HIGH: assert reset. Expect all outputs at reset values immediately, FIFO empty, and the next push getting tag 0.
- With HDC_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=64: never raise done. Expect res_valid with res_err=1 and res_data=0, then the next job completes with res_err=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared types for the horizontal-distance calculator job dispatcher.
// Job struct widths track HDC_DATA_W / HDC_TAG_W; the dispatcher defaults to the same values.
package hdc_pkg;

  localparam int HDC_DATA_W = 16;
  localparam int HDC_TAG_W  = 4;

  // Q5.11 unity
  localparam logic [HDC_DATA_W-1:0] FIXED_ONE = 16'h0800;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH
  } hdc_state_t;

  typedef struct packed {
    logic [HDC_DATA_W-1:0] v;
    logic [HDC_DATA_W-1:0] x;
    logic [HDC_TAG_W-1:0]  tag;
  } hdc_job_t;

endpackage

// File: rtl/hdc_job_dispatcher_if.sv
// Job input stream, core-side start/operand/done signals and tagged result stream.
// master = dispatcher view, slave = the surrounding system (job source, core, result sink).
interface hdc_job_dispatcher_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              job_valid;
  logic              job_ready;
  logic [DATA_W-1:0] job_v;
  logic [DATA_W-1:0] job_x;
  logic              calc_start;
  logic [DATA_W-1:0] calc_v;
  logic [DATA_W-1:0] calc_x;
  logic              calc_done;
  logic [DATA_W-1:0] calc_result;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;
  logic              busy;

  modport master (
    input  job_valid, job_v, job_x, calc_done, calc_result, res_ready,
    output job_ready, calc_start, calc_v, calc_x, res_valid, res_data, res_tag, res_err, busy
  );

  modport slave (
    output job_valid, job_v, job_x, calc_done, calc_result, res_ready,
    input  job_ready, calc_start, calc_v, calc_x, res_valid, res_data, res_tag, res_err, busy
  );
endinterface

// File: rtl/hdc_sync_fifo.sv
// Generic synchronous FIFO, show-ahead read (pop_dat valid whenever !empty), zero-latency flags.
// Backpressure: push ignored when full, pop ignored when empty; the caller gates on full/empty.
module hdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/hdc_job_dispatcher.sv
// Queues (v,x) jobs, starts the core with a 1-cycle pulse, returns tagged results; push->start 2 cycles, done->res_valid 1 cycle.
// Backpressure: job_ready = !full; no new job pops while a result is held. HDC_DISPATCH_TIMEOUT_EN adds a watchdog abort.
module hdc_job_dispatcher
  import hdc_pkg::*;
#(
  parameter int DATA_W         = HDC_DATA_W,
  parameter int DEPTH          = 4,
  parameter int TAG_W          = HDC_TAG_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                 clk,
  input logic                 reset,
  hdc_job_dispatcher_if.master io
);

  hdc_state_t        state;
  hdc_job_t          wr_job;
  hdc_job_t          rd_job;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [TAG_W-1:0]  tag_cnt;
  logic [TAG_W-1:0]  cur_tag;
  logic              calc_start_q;
  logic [DATA_W-1:0] calc_v_q;
  logic [DATA_W-1:0] calc_x_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [TAG_W-1:0]  res_tag_q;

`ifdef HDC_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog;
  logic            res_err_q;
`endif

  assign push   = io.job_valid & ~fifo_full;
  // A job only leaves the FIFO when its result will have somewhere to land.
  assign pop    = (state == IDLE) & ~fifo_empty & (~res_valid_q | io.res_ready);
  assign wr_job = '{v: io.job_v, x: io.job_x, tag: tag_cnt};

  hdc_sync_fifo #(
    .WIDTH ($bits(hdc_job_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (wr_job),
    .pop      (pop),
    .pop_dat  (rd_job),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur_tag      <= '0;
      calc_start_q <= 1'b0;
      calc_v_q     <= '0;
      calc_x_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
`ifdef HDC_DISPATCH_TIMEOUT_EN
      wdog         <= '0;
      res_err_q    <= 1'b0;
`endif
    end else begin
      calc_start_q <= 1'b0;
      if (res_valid_q && io.res_ready) res_valid_q <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          calc_v_q     <= rd_job.v;
          calc_x_q     <= rd_job.x;
          cur_tag      <= rd_job.tag;
          calc_start_q <= 1'b1;
          state        <= START;
        end
        START: begin
          state <= WAIT_LOW;
`ifdef HDC_DISPATCH_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        // A done still high from the previous job must fall before we trust a rise.
        WAIT_LOW: if (!io.calc_done) state <= WAIT_HIGH;
        WAIT_HIGH: if (io.calc_done) begin
          res_valid_q <= 1'b1;
          res_data_q  <= io.calc_result;
          res_tag_q   <= cur_tag;
`ifdef HDC_DISPATCH_TIMEOUT_EN
          res_err_q   <= 1'b0;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef HDC_DISPATCH_TIMEOUT_EN
      if ((state == WAIT_LOW) || (state == WAIT_HIGH && !io.calc_done)) begin
        if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          res_valid_q <= 1'b1;
          res_data_q  <= '0;
          res_tag_q   <= cur_tag;
          res_err_q   <= 1'b1;
          state       <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
`endif
    end
  end

  assign io.job_ready  = ~fifo_full;
  assign io.calc_start = calc_start_q;
  assign io.calc_v     = calc_v_q;
  assign io.calc_x     = calc_x_q;
  assign io.res_valid  = res_valid_q;
  assign io.res_data   = res_data_q;
  assign io.res_tag    = res_tag_q;
  assign io.busy       = (state != IDLE) | ~fifo_empty;
`ifdef HDC_DISPATCH_TIMEOUT_EN
  assign io.res_err    = res_err_q;
`else
  assign io.res_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hdc_job_dispatcher.sv
// Directed bench for hdc_job_dispatcher: vector table of single jobs plus burst, backpressure,
// stale-done, reset and watchdog sequences; the core is a small model returning v - x.
module tb_hdc_job_dispatcher;
  import hdc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hdc_job_dispatcher_if #(.DATA_W(16), .TAG_W(4)) io ();

  hdc_job_dispatcher #(
    .DATA_W(16), .DEPTH(4), .TAG_W(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Core model: start clears done, done rises core_lat cycles later with v - x.
  logic        core_auto = 1'b1;
  int          core_lat  = 10;
  logic        model_done = 1'b0;
  logic [15:0] model_res  = '0;
  int          model_cnt  = 0;
  logic        man_done   = 1'b0;
  logic [15:0] man_result = '0;

  assign io.calc_done   = core_auto ? model_done : man_done;
  assign io.calc_result = core_auto ? model_res  : man_result;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      model_done = 1'b0;
      model_cnt  = 0;
    end else if (io.calc_start) begin
      model_done = 1'b0;
      model_cnt  = core_lat;
      model_res  = io.calc_v - io.calc_x;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_job(input logic [15:0] v, input logic [15:0] x);
    int k = 0;
    io.job_valid = 1'b1;
    io.job_v     = v;
    io.job_x     = x;
    while (!io.job_ready && k < 200) begin @(negedge clk); k++; end
    chk("push_accepted", {31'd0, io.job_ready}, 32'd1);
    @(negedge clk);
    io.job_valid = 1'b0;
  endtask

  task automatic wait_start(input int limit);
    int k = 0;
    while (!io.calc_start && k < limit) begin @(negedge clk); k++; end
    chk("start_seen", {31'd0, io.calc_start}, 32'd1);
  endtask

  task automatic wait_res(input int limit, output int k);
    k = 0;
    while (!io.res_valid && k < limit) begin @(negedge clk); k++; end
    chk("res_seen", {31'd0, io.res_valid}, 32'd1);
  endtask

  // Single job from idle+empty with result slot free; all timing checks exact.
  task automatic run_job(input logic [15:0] v, input logic [15:0] x, input int lat,
                         input logic [15:0] exp_res, input logic [3:0] exp_tag);
    int k;
    core_lat = lat;
    push_job(v, x);
    k = 1;
    while (!io.calc_start && k < 20) begin @(negedge clk); k++; end
    chk("start_latency", k, 2);
    k = 0;
    while (!io.calc_done && k < 200) begin @(negedge clk); k++; end
    chk("done_seen", {31'd0, io.calc_done}, 32'd1);
    chk("res_valid_early", {31'd0, io.res_valid}, 32'd0);
    chk("calc_v_hold", {16'd0, io.calc_v}, {16'd0, v});
    chk("calc_x_hold", {16'd0, io.calc_x}, {16'd0, x});
    @(negedge clk);
    chk("res_valid", {31'd0, io.res_valid}, 32'd1);
    chk("res_data", {16'd0, io.res_data}, {16'd0, exp_res});
    chk("res_tag", {28'd0, io.res_tag}, {28'd0, exp_tag});
    chk("res_err", {31'd0, io.res_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] v;
    logic [15:0] x;
    int          lat;
    logic [15:0] exp_res;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    logic [15:0] bv [5];
    logic [15:0] bx [5];

    vecs[0] = '{16'h1000, 16'h0400, 10, 16'h0C00, 4'd0};
    vecs[1] = '{16'h0000, 16'h0000, 2,  16'h0000, 4'd1};
    vecs[2] = '{16'hFFFF, 16'h0001, 5,  16'hFFFE, 4'd2};
    vecs[3] = '{FIXED_ONE, 16'h0200, 3, 16'h0600, 4'd3};
    vecs[4] = '{16'h8000, 16'h7FFF, 7,  16'h0001, 4'd4};

    io.job_valid = 1'b0;
    io.job_v     = '0;
    io.job_x     = '0;
    io.res_ready = 1'b1;

    #1;
    chk("rst_res_valid", {31'd0, io.res_valid}, 32'd0);
    chk("rst_calc_start", {31'd0, io.calc_start}, 32'd0);
    chk("rst_res_data", {16'd0, io.res_data}, 32'd0);
    chk("rst_busy", {31'd0, io.busy}, 32'd0);
    chk("rst_job_ready", {31'd0, io.job_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_job(vecs[i].v, vecs[i].x, vecs[i].lat, vecs[i].exp_res, vecs[i].exp_tag);

    // Tag counter wraps 15 -> 0 without gaps.
    for (int i = 0; i < 16; i++)
      run_job(16'(i * 16'h0111), 16'h0010, 2, 16'(i * 16'h0111) - 16'h0010, 4'((5 + i) % 16));

    // Burst of 5 into a 4-deep FIFO behind a slow core.
    do_reset();
    core_lat = 30;
    for (int i = 0; i < 5; i++) begin
      bv[i] = 16'(16'h0100 * (i + 1));
      bx[i] = 16'(i);
      push_job(bv[i], bx[i]);
    end
    chk("burst_full_ready", {31'd0, io.job_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_res(200, k);
      chk("burst_data", {16'd0, io.res_data}, {16'd0, bv[i] - bx[i]});
      chk("burst_tag", {28'd0, io.res_tag}, 32'(i));
      @(negedge clk);
    end

    // Held result blocks the next job.
    do_reset();
    core_lat = 4;
    io.res_ready = 1'b0;
    push_job(16'h2000, 16'h0100);
    push_job(16'h0300, 16'h0100);
    wait_res(100, k);
    chk("bp_first_data", {16'd0, io.res_data}, 32'h1F00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_data_stable", {16'd0, io.res_data}, 32'h1F00);
      chk("bp_no_start", {31'd0, io.calc_start}, 32'd0);
      chk("bp_valid_held", {31'd0, io.res_valid}, 32'd1);
    end
    io.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_start", {31'd0, io.calc_start}, 32'd1);
    chk("bp_release_drain", {31'd0, io.res_valid}, 32'd0);
    wait_res(100, k);
    chk("bp_second_data", {16'd0, io.res_data}, 32'h0200);
    chk("bp_second_tag", {28'd0, io.res_tag}, 32'd1);

    // Stale done held through START must not complete the job.
    do_reset();
    core_auto = 1'b0;
    man_done  = 1'b1;
    man_result = 16'h0777;
    push_job(16'h0100, 16'h0020);
    wait_start(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stale_no_res", {31'd0, io.res_valid}, 32'd0);
    end
    man_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stale_low_no_res", {31'd0, io.res_valid}, 32'd0);
    end
    man_result = 16'h0ABC;
    man_done   = 1'b1;
    chk("stale_rise_not_yet", {31'd0, io.res_valid}, 32'd0);
    @(negedge clk);
    chk("stale_res_valid", {31'd0, io.res_valid}, 32'd1);
    chk("stale_res_data", {16'd0, io.res_data}, 32'h0ABC);
    chk("stale_res_tag", {28'd0, io.res_tag}, 32'd0);

    // Reset while waiting for done with another job queued.
    push_job(16'h1234, 16'h0034);
    wait_start(20);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    push_job(16'h5555, 16'h1111);
    chk("pre_rst_busy", {31'd0, io.busy}, 32'd1);
    chk("pre_rst_data", {16'd0, io.res_data}, 32'h0ABC);
    reset = 1'b1;
    #1;
    chk("mid_rst_calc_v", {16'd0, io.calc_v}, 32'd0);
    chk("mid_rst_calc_x", {16'd0, io.calc_x}, 32'd0);
    chk("mid_rst_start", {31'd0, io.calc_start}, 32'd0);
    chk("mid_rst_valid", {31'd0, io.res_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, io.res_data}, 32'd0);
    chk("mid_rst_tag", {28'd0, io.res_tag}, 32'd0);
    chk("mid_rst_err", {31'd0, io.res_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, io.busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, io.job_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    core_auto = 1'b1;
    run_job(16'h0900, 16'h0100, 6, 16'h0800, 4'd0);

    // Core that never finishes.
    core_auto = 1'b0;
    man_done  = 1'b0;
    push_job(16'h0042, 16'h0002);
    wait_start(20);
`ifdef HDC_DISPATCH_TIMEOUT_EN
    wait_res(200, k);
    chk("wd_cycles", k, 65);
    chk("wd_err", {31'd0, io.res_err}, 32'd1);
    chk("wd_data", {16'd0, io.res_data}, 32'd0);
    chk("wd_tag", {28'd0, io.res_tag}, 32'd1);
    @(negedge clk);
    push_job(16'h0460, 16'h000A);
    wait_start(20);
    repeat (2) @(negedge clk);
    man_result = 16'h0456;
    man_done   = 1'b1;
    @(negedge clk);
    chk("wd_next_valid", {31'd0, io.res_valid}, 32'd1);
    chk("wd_next_err", {31'd0, io.res_err}, 32'd0);
    chk("wd_next_data", {16'd0, io.res_data}, 32'h0456);
    chk("wd_next_tag", {28'd0, io.res_tag}, 32'd2);
`else
    repeat (100) @(negedge clk);
    chk("nodone_no_res", {31'd0, io.res_valid}, 32'd0);
    chk("nodone_busy", {31'd0, io.busy}, 32'd1);
    chk("nodone_err", {31'd0, io.res_err}, 32'd0);
    man_result = 16'h0321;
    man_done   = 1'b1;
    @(negedge clk);
    chk("late_done_valid", {31'd0, io.res_valid}, 32'd1);
    chk("late_done_data", {16'd0, io.res_data}, 32'h0321);
    chk("late_done_tag", {28'd0, io.res_tag}, 32'd1);
    chk("late_done_err", {31'd0, io.res_err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
